// File: rtl/brew_step_controller.sv
// Recipe timing controller: paces the 5-step stepper through programmed step
// durations, decodes the step code into actuator commands, and runs the start/done/abort handshake.
module brew_step_controller #(
    parameter int CNT_W  = 16,
    parameter int DUR_S1 = 100,
    parameter int DUR_S2 = 200,
    parameter int DUR_S3 = 150,
    parameter int DUR_S4 = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] step,
    output logic       step_en,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       fault,
    output logic       grinder,
    output logic       heater,
    output logic       pump,
    output logic       serve
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_FLUSH,
        S_FIN,
        S_FAULT
    } state_t;

    // A programmed duration of 0 behaves as 1; the counter is loaded with duration-1.
    localparam int D1 = (DUR_S1 < 1) ? 1 : DUR_S1;
    localparam int D2 = (DUR_S2 < 1) ? 1 : DUR_S2;
    localparam int D3 = (DUR_S3 < 1) ? 1 : DUR_S3;
    localparam int D4 = (DUR_S4 < 1) ? 1 : DUR_S4;
    localparam logic [CNT_W-1:0] RELOAD_S1 = CNT_W'(D1 - 1);
    localparam logic [CNT_W-1:0] RELOAD_S2 = CNT_W'(D2 - 1);
    localparam logic [CNT_W-1:0] RELOAD_S3 = CNT_W'(D3 - 1);
    localparam logic [CNT_W-1:0] RELOAD_S4 = CNT_W'(D4 - 1);

    state_t           state, state_nx;
    logic [2:0]       idx, idx_nx, idx_inc;
    logic [CNT_W-1:0] cnt, cnt_nx, reload;
    logic             abort_flag, abort_flag_nx;

    // idx tracks the step code the stepper will present once any pending advance lands.
    assign idx_inc = (idx == 3'd4) ? 3'd0 : 3'(idx + 3'd1);

    always_comb begin
        case (idx_inc)
            3'd1:    reload = RELOAD_S1;
            3'd2:    reload = RELOAD_S2;
            3'd3:    reload = RELOAD_S3;
            3'd4:    reload = RELOAD_S4;
            default: reload = '0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= 3'd0;
            cnt        <= '0;
            abort_flag <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            abort_flag <= abort_flag_nx;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        cnt_nx        = cnt;
        abort_flag_nx = abort_flag;

        if (step_en) begin
            idx_nx = idx_inc;
            cnt_nx = reload;
        end else if (state == S_RUN) begin
            cnt_nx = cnt - 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (step == 3'd0) begin
                        state_nx      = S_START;
                        abort_flag_nx = 1'b0;
                    end else begin
                        state_nx = S_FAULT;
                    end
                end
            end
            S_START: state_nx = S_RUN;
            S_RUN: begin
                // Desync beats everything; a wrapping advance beats a same-cycle abort.
                if (step != idx) begin
                    state_nx = S_FAULT;
                end else if (step_en && idx_inc == 3'd0) begin
                    state_nx = S_FIN;
                end else if (abort) begin
                    state_nx      = S_FLUSH;
                    abort_flag_nx = 1'b1;
                end
            end
            S_FLUSH: begin
                if (idx_inc == 3'd0) state_nx = S_FIN;
            end
            S_FIN: begin
                state_nx = (step == 3'd0) ? S_IDLE : S_FAULT;
            end
            S_FAULT: state_nx = S_FAULT;
            default: state_nx = S_FAULT;
        endcase
    end

    always_comb begin
        step_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        aborted = 1'b0;
        fault   = 1'b0;
        grinder = 1'b0;
        heater  = 1'b0;
        pump    = 1'b0;
        serve   = 1'b0;

        case (state)
            S_START: begin
                step_en = 1'b1;
                busy    = 1'b1;
            end
            S_RUN: begin
                step_en = (cnt == '0);
                busy    = 1'b1;
                grinder = (step == 3'd1);
                heater  = (step == 3'd2);
                pump    = (step == 3'd3);
                serve   = (step == 3'd4);
            end
            S_FLUSH: begin
                step_en = 1'b1;
                busy    = 1'b1;
            end
            S_FIN: begin
                done    = !abort_flag && (step == 3'd0);
                aborted = abort_flag && (step == 3'd0);
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule
